// File: rtl/ecc_pkg.sv
// Shared constants and sequencer state encoding for the Montgomery-ladder scalar multiplier.
package ecc_pkg;

  localparam int unsigned KW = 256;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StEmit = 2'd2,
    StFin  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ladder_bit_seq.sv
// Scalar-bit sequencer: skips leading zeros of k, flags ladder init on the leading one,
// then hands the remaining bits MSB-first to the ladder step under a valid/ack handshake.
module ladder_bit_seq
  import ecc_pkg::*;
#(
  parameter int unsigned KW = ecc_pkg::KW,
  parameter int unsigned TW = ecc_pkg::TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic          bit_ack,
  output logic          busy,
  output logic          init_req,
  output logic          bit_vld,
  output logic          kt,
  output logic [TW-1:0] t_idx,
  output logic          done,
  output logic          zero_k
);

  seq_state_e    state_q, state_d;
  logic [KW-1:0] ksh_q, ksh_d;
  logic [TW-1:0] t_q, t_d;
  logic          zflag_q, zflag_d;
  logic          top_bit;
  logic          last;

  // ksh_q[KW-1] always mirrors k[t_q] of the loaded scalar.
  assign top_bit = ksh_q[KW-1];
  assign last    = (t_q == '0);

  always_comb begin
    state_d = state_q;
    ksh_d   = ksh_q;
    t_d     = t_q;
    zflag_d = zflag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ksh_d   = k;
          t_d     = TW'(KW - 1);
          zflag_d = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (last) begin
          zflag_d = ~top_bit;
          state_d = StFin;
        end else begin
          ksh_d = {ksh_q[KW-2:0], 1'b0};
          t_d   = t_q - 1'b1;
          if (top_bit) begin
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (bit_ack) begin
          if (last) begin
            state_d = StFin;
          end else begin
            ksh_d = {ksh_q[KW-2:0], 1'b0};
            t_d   = t_q - 1'b1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ksh_q   <= '0;
      t_q     <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ksh_q   <= ksh_d;
      t_q     <= t_d;
      zflag_q <= zflag_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign init_req = (state_q == StScan) && top_bit;
  assign bit_vld  = (state_q == StEmit);
  assign kt       = top_bit;
  assign t_idx    = t_q;
  assign done     = (state_q == StFin);
  assign zero_k   = (state_q == StFin) && zflag_q;

endmodule

// File: tb/tb_ladder_bit_seq.sv
// Bench for ladder_bit_seq: per-cycle comparison against a queue-based model of the
// scalar walk, plus literal expectations for each directed scenario.
module tb_ladder_bit_seq;

  localparam int KWI = int'(ecc_pkg::KW);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [ecc_pkg::KW-1:0]  k = '0;
  logic                    bit_ack = 1'b0;
  logic                    busy, init_req, bit_vld, kt, done, zero_k;
  logic [ecc_pkg::TW-1:0]  t_idx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_mode = 0;

  // Model state: scalar, remaining scan cycles, queue of bit indices still to emit.
  logic                    m_busy = 1'b0;
  logic                    m_fin = 1'b0;
  int                      m_scan = 0;
  int                      m_msb = -1;
  int                      m_t = 0;
  logic [ecc_pkg::KW-1:0]  m_k = '0;
  int                      m_bits[$];

  // Observations gathered per scenario.
  int init_cyc, init_cnt, done_cnt, done_cyc, vld_cnt;
  logic done_zero;
  int cap[$];

  logic [13:0] exp_v, act_v;

  ladder_bit_seq #(
    .KW(ecc_pkg::KW),
    .TW(ecc_pkg::TW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k       (k),
    .bit_ack (bit_ack),
    .busy    (busy),
    .init_req(init_req),
    .bit_vld (bit_vld),
    .kt      (kt),
    .t_idx   (t_idx),
    .done    (done),
    .zero_k  (zero_k)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int msb_of(input logic [ecc_pkg::KW-1:0] v);
    for (int i = KWI - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare, observe, then advance the model with the inputs the next edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      exp_v = {m_busy, m_busy && !m_fin && m_scan == 1 && m_msb >= 0,
               m_busy && !m_fin && m_scan == 0, m_k[m_t], m_fin, m_fin && m_msb < 0, 8'(m_t)};
      act_v = {busy, init_req, bit_vld, kt, done, zero_k, t_idx};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
      end
      if (init_req) begin
        init_cnt++;
        init_cyc = cyc;
      end
      if (bit_vld) vld_cnt++;
      if (bit_vld && bit_ack) cap.push_back(int'(t_idx) * 2 + int'(kt));
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_zero = zero_k;
      end
      if (rst) begin
        m_busy = 1'b0;
        m_fin  = 1'b0;
        m_scan = 0;
        m_msb  = -1;
        m_t    = 0;
        m_k    = '0;
        m_bits.delete();
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_fin  = 1'b0;
          m_k    = k;
          m_msb  = msb_of(k);
          m_scan = (m_msb < 0) ? KWI : KWI - m_msb;
          m_t    = KWI - 1;
          m_bits.delete();
          for (int i = m_msb - 1; i >= 0; i--) m_bits.push_back(i);
        end
      end else if (m_fin) begin
        m_busy = 1'b0;
        m_fin  = 1'b0;
      end else if (m_scan > 0) begin
        m_scan--;
        if (m_scan == 0) begin
          if (m_bits.size() == 0) m_fin = 1'b1;
          else m_t = m_bits[0];
        end else begin
          m_t--;
        end
      end else if (bit_ack) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) m_fin = 1'b1;
        else m_t = m_bits[0];
      end
    end
  end

  // Ack driver: 0 = never, 1 = always, 2 = five idle cycles then ack for each bit.
  initial begin
    int sc;
    sc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        1: bit_ack = 1'b1;
        2: begin
          if (bit_vld) begin
            if (sc == 5) begin
              bit_ack = 1'b1;
              sc = 0;
            end else begin
              bit_ack = 1'b0;
              sc++;
            end
          end else begin
            bit_ack = 1'b0;
          end
        end
        default: bit_ack = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_mon();
    init_cyc  = -1;
    init_cnt  = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    done_zero = 1'b0;
    vld_cnt   = 0;
    cap.delete();
  endtask

  task automatic run(input logic [ecc_pkg::KW-1:0] kv, output int c);
    start = 1'b1;
    k     = kv;
    c     = cyc;
    tick();
    start = 1'b0;
    k     = ~kv;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, done_cnt, 1);
  endtask

  initial begin
    int c, bad, idx;
    logic [ecc_pkg::KW-1:0] kv;

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outs", int'({busy, init_req, bit_vld, kt, done, zero_k, t_idx}), 0);
    tick();

    // k = 5, ack tied high
    ack_mode = 1;
    clear_mon();
    kv = 256'd5;
    run(kv, c);
    wait_done("k5", 400);
    chk("k5_init_cyc", init_cyc - c, 254);
    chk("k5_init_cnt", init_cnt, 1);
    chk("k5_nbits", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("k5_bit0", cap[0], 2);
      chk("k5_bit1", cap[1], 1);
    end
    chk("k5_done_cyc", done_cyc - c, 257);
    chk("k5_zero", int'(done_zero), 0);
    chk("k5_busy_after", int'(busy), 0);

    // k = 0
    clear_mon();
    run('0, c);
    wait_done("k0", 400);
    chk("k0_init_cnt", init_cnt, 0);
    chk("k0_vld_cnt", vld_cnt, 0);
    chk("k0_done_cyc", done_cyc - c, 257);
    chk("k0_zero", int'(done_zero), 1);

    // k = 1
    clear_mon();
    run(256'd1, c);
    wait_done("k1", 400);
    chk("k1_init_cyc", init_cyc - c, 256);
    chk("k1_nbits", cap.size(), 0);
    chk("k1_done_cyc", done_cyc - c, 257);
    chk("k1_zero", int'(done_zero), 0);

    // k = 2^255 + 3 with a five-cycle stall on every bit
    ack_mode = 2;
    clear_mon();
    kv = '0;
    kv[255] = 1'b1;
    kv[1] = 1'b1;
    kv[0] = 1'b1;
    run(kv, c);
    wait_done("kbig", 2000);
    chk("kbig_init_cyc", init_cyc - c, 1);
    chk("kbig_nbits", cap.size(), 255);
    bad = 0;
    for (int i = 0; i < cap.size(); i++) begin
      idx = 254 - i;
      if (cap[i] != idx * 2 + ((idx < 2) ? 1 : 0)) bad++;
    end
    chk("kbig_bit_errs", bad, 0);
    chk("kbig_vld_cnt", vld_cnt, 1530);
    chk("kbig_done_cyc", done_cyc - c, 1532);

    // start pulsed mid-EMIT is ignored
    ack_mode = 1;
    clear_mon();
    run(256'd1029, c);
    begin
      int n;
      n = 0;
      while (!bit_vld && n < 400) begin
        tick();
        n++;
      end
    end
    start = 1'b1;
    k = '1;
    tick();
    start = 1'b0;
    wait_done("restart", 400);
    chk("restart_nbits", cap.size(), 10);
    bad = 0;
    for (int i = 0; i < cap.size(); i++) begin
      idx = 9 - i;
      if (cap[i] != idx * 2 + ((idx == 2 || idx == 0) ? 1 : 0)) bad++;
    end
    chk("restart_bit_errs", bad, 0);
    chk("restart_done_cyc", done_cyc - c, 257);
    repeat (3) tick();
    chk("restart_done_cnt", done_cnt, 1);

    // reset mid-EMIT at t = 100, then a fresh k = 6
    clear_mon();
    kv = '0;
    kv[200] = 1'b1;
    kv[100] = 1'b1;
    run(kv, c);
    begin
      int n;
      n = 0;
      while (!(bit_vld && t_idx == 8'd100) && n < 600) begin
        tick();
        n++;
      end
    end
    chk("rst_reached_t100", int'(bit_vld && t_idx == 8'd100), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", int'({busy, bit_vld, done, t_idx}), 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("rst_no_done", done_cnt, 0);
    clear_mon();
    run(256'd6, c);
    wait_done("k6", 400);
    chk("k6_nbits", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("k6_bit0", cap[0], 3);
      chk("k6_bit1", cap[1], 0);
    end
    chk("k6_init_cyc", init_cyc - c, 254);
    chk("k6_done_cyc", done_cyc - c, 257);
    chk("k6_zero", int'(done_zero), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ladder_bit_seq.md
Name: ladder_bit_seq

Overview:
- Scalar-bit sequencer for the Montgomery-ladder scalar multiplier. Loads a 256-bit scalar k and skips its leading zeros.
- Signals ladder initialisation on the leading one (R0=P, R1=2P), then presents the remaining bits k[t], MSB-first, to the downstream ladder ALU step.
- Presentation uses a valid/ack handshake, one bit per completed ladder step.
- Replaces the free-running t counter and k[t] bit-select with a controlled, stall-able index stream.

Parameters:
- KW, 256, scalar width in bits.
- TW, 8, index width; must equal clog2(KW).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to load k; honoured only in IDLE.
- k  input  KW  scalar; sampled only on an accepted start.
- bit_ack  input  1  ladder step consumed the current bit; ignored unless bit_vld=1.
- busy  output  1  high in every state except IDLE.
- init_req  output  1  one-cycle pulse when the leading one is found.
- bit_vld  output  1  kt/t_idx valid, held until bit_ack.
- kt  output  1  current scalar bit k[t_idx].
- t_idx  output  TW  index of current bit.
- done  output  1  one-cycle pulse at end of scalar.
- zero_k  output  1  valid with done: scalar was zero, result is point at infinity.

Behaviour:
- Registers: state, ksh[KW-1:0] (left-shift copy of k), t[TW-1:0], zflag.
- All outputs are decoded from registered state only; there is no input-to-output combinational path.
- kt = ksh[KW-1]; t_idx = t.
- rst: state=IDLE, ksh=0, t=0, zflag=0. All outputs are 0 during and after reset. Reset mid-operation aborts immediately; no done pulse.
- IDLE: start=1 latches ksh<=k, t<=KW-1, zflag<=0, and goes to SCAN next cycle.
- SCAN, ksh[KW-1]=0:
  - if t==0: zflag<=1, go to FIN;
  - else shift ksh left by 1, t<=t-1.
- SCAN, ksh[KW-1]=1:
  - init_req=1 this cycle;
  - if t==0 (k==1): go to FIN, no bits emitted;
  - else shift, t<=t-1, go to EMIT.
- EMIT: bit_vld=1.
  - On bit_ack: if t==0 go to FIN, else shift, t<=t-1, stay in EMIT.
  - Without ack: kt, t_idx and bit_vld are held indefinitely.
- FIN: done=1, zero_k=zflag for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- Latency: start accepted at cycle c.
  - SCAN occupies cycles c+1 .. c+1+(KW-1-msb). init_req fires at cycle c+1+(KW-1-msb).
  - Emitted bit count = msb (index of the leading one). Zero-k reaches FIN at c+1+KW.
- start while busy is ignored; k changes while busy have no effect.
- start and rst in the same cycle: reset wins.
- bit_ack held continuously: one bit per cycle.
- Shift is a logical left shift with zero fill; t never wraps below 0.

Decomposition:
- Shared package ecc_pkg holds:
  - KW/TW constants;
  - state encoding IDLE=2'd0, SCAN=2'd1, EMIT=2'd2, FIN=2'd3.
- The downstream ladder ALU imports the same constants.
- No sub-module: the FSM, shift register and down-counter are small enough to sit in one module.

Test Plan:
- k=5, bit_ack tied 1, start at cycle 0:
  - SCAN t=255..3 (253 cycles), init_req at t=2;
  - EMIT (t=1,kt=0), (t=0,kt=1);
  - done, zero_k=0; busy low after.
- k=0: no init_req, no bit_vld; done with zero_k=1 at cycle 257 after start.
- k=1: init_req at t=0, zero bits emitted, done next cycle, zero_k=0.
- k=2^255+3, bit_ack low for 5 cycles each bit:
  - init_req on the first SCAN cycle;
  - 255 bits emitted, t_idx 254..0, last two kt=1, others 0;
  - outputs stable while stalled.
- start pulsed again mid-EMIT with a different k: ignored; original sequence completes unchanged.
- rst asserted mid-EMIT (t=100): next cycle busy=0, bit_vld=0, t_idx=0, no done. A fresh start with k=6 then runs correctly: bits (1,1),(0,0).
